spike_window_decoder: RTL and testbench

- Output-decoding stage that sits directly downstream of the two-neuron output layer.
- Consumes the two output spike lines and counts spikes per channel over a fixed window of clock cycles.
- At the end of each window it presents the per-channel counts plus a winner/tie classification on a valid/ready interface for the host or readout logic.

---
 rtl/spike_window_decoder.sv | 133 +++++++++++++
 tb/tb_spike_window_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_window_decoder.sv
// Counts per-channel output spikes over WINDOW cycles and classifies winner/tie; result valid 1 cycle after the last window cycle.
// Result is held in HOLD until out_valid&out_ready; spikes arriving while held are dropped and flagged via sticky missed.
module spike_window_decoder #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       spike_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic             winner,
    output logic             tie,
    output logic             missed
);

    localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0]  LAST_CYCLE = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] SAT        = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  acc0_q, acc0_d;
    logic [CNT_W-1:0]  acc1_q, acc1_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  count0_q, count0_d;
    logic [CNT_W-1:0]  count1_q, count1_d;
    logic              winner_q, winner_d;
    logic              tie_q, tie_d;
    logic              missed_q, missed_d;

    // Saturating next values including this cycle's spikes.
    logic [CNT_W-1:0]  acc0_nxt, acc1_nxt;

    always_comb begin
        acc0_nxt = acc0_q;
        acc1_nxt = acc1_q;
        if (spike_in[0] && (acc0_q != SAT)) acc0_nxt = acc0_q + CNT_W'(1);
        if (spike_in[1] && (acc1_q != SAT)) acc1_nxt = acc1_q + CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        out_valid_d = out_valid_q;
        count0_d    = count0_q;
        count1_d    = count1_q;
        winner_d    = winner_q;
        tie_d       = tie_q;
        missed_d    = missed_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = S_ACCUM;
                    win_cnt_d = '0;
                    acc0_d    = '0;
                    acc1_d    = '0;
                end
            end
            S_ACCUM: begin
                acc0_d    = acc0_nxt;
                acc1_d    = acc1_nxt;
                win_cnt_d = win_cnt_q + WC_W'(1);
                if (win_cnt_q == LAST_CYCLE) begin
                    count0_d    = acc0_nxt;
                    count1_d    = acc1_nxt;
                    winner_d    = (acc1_nxt > acc0_nxt);
                    tie_d       = (acc1_nxt == acc0_nxt);
                    out_valid_d = 1'b1;
                    win_cnt_d   = '0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (|spike_in) missed_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc0_d      = '0;
                    acc1_d      = '0;
                    win_cnt_d   = '0;
                    state_d     = en ? S_ACCUM : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            out_valid_q <= 1'b0;
            count0_q    <= '0;
            count1_q    <= '0;
            winner_q    <= 1'b0;
            tie_q       <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            out_valid_q <= out_valid_d;
            count0_q    <= count0_d;
            count1_q    <= count1_d;
            winner_q    <= winner_d;
            tie_q       <= tie_d;
            missed_q    <= missed_d;
        end
    end

    assign out_valid = out_valid_q;
    assign count0    = count0_q;
    assign count1    = count1_q;
    assign winner    = winner_q;
    assign tie       = tie_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: window table plus hand sequences for
// back-pressure, reset mid-window, back-to-back ties and saturation.
module tb_spike_window_decoder;

    logic       clk;
    logic       rst, en, out_ready;
    logic [1:0] spike_in;
    logic       out_valid, winner, tie, missed;
    logic [7:0] count0, count1;

    logic       s_rst, s_en, s_out_ready;
    logic [1:0] s_spike_in;
    logic       s_out_valid, s_winner, s_tie, s_missed;
    logic [3:0] s_count0, s_count1;

    int checks = 0;
    int failures = 0;

    spike_window_decoder #(.WINDOW(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .out_ready(out_ready),
        .out_valid(out_valid), .count0(count0), .count1(count1),
        .winner(winner), .tie(tie), .missed(missed)
    );

    spike_window_decoder #(.WINDOW(32), .CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst), .en(s_en), .spike_in(s_spike_in), .out_ready(s_out_ready),
        .out_valid(s_out_valid), .count0(s_count0), .count1(s_count1),
        .winner(s_winner), .tie(s_tie), .missed(s_missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] m0;
        logic [15:0] m1;
        int          c0;
        int          c1;
        logic        win;
        logic        tie;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drives one window of spikes from the masks (bit i = i-th ACCUM cycle) and
    // returns the number of edges until out_valid is seen (0 if never).
    task automatic feed(input logic [15:0] m0, input logic [15:0] m1, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            spike_in = (i < 16) ? {m1[i], m0[i]} : 2'b00;
            tick();
            if (out_valid) begin
                lat = i + 1;
                break;
            end
        end
        spike_in = 2'b00;
    endtask

    task automatic run_window(input logic [15:0] m0, input logic [15:0] m1, output int lat);
        en = 1'b1;
        tick();
        en = 1'b0;
        feed(m0, m1, lat);
    endtask

    initial begin
        int   lat;
        logic stable;
        logic [7:0] ref_c0, ref_c1;
        logic ref_w, ref_t;

        vecs[0] = '{m0: 16'h8431, m1: 16'h0700, c0: 5,  c1: 3,  win: 1'b0, tie: 1'b0};
        vecs[1] = '{m0: 16'h0000, m1: 16'h0000, c0: 0,  c1: 0,  win: 1'b0, tie: 1'b1};
        vecs[2] = '{m0: 16'h00F0, m1: 16'hF0F0, c0: 4,  c1: 8,  win: 1'b1, tie: 1'b0};
        vecs[3] = '{m0: 16'hFFFF, m1: 16'hFFFF, c0: 16, c1: 16, win: 1'b0, tie: 1'b1};
        vecs[4] = '{m0: 16'h8001, m1: 16'h0000, c0: 2,  c1: 0,  win: 1'b0, tie: 1'b0};

        rst = 1'b1; en = 1'b0; out_ready = 1'b0; spike_in = 2'b00;
        s_rst = 1'b1; s_en = 1'b0; s_out_ready = 1'b0; s_spike_in = 2'b00;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_counts", {count0, count1}, 0);
        chk("rst_flags", {winner, tie, missed}, 0);
        rst = 1'b0;
        s_rst = 1'b0;

        // Idle with spikes present: nothing may be counted or flagged.
        stable = 1'b1;
        spike_in = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid || missed) stable = 1'b0;
        end
        spike_in = 2'b00;
        chk("idle_quiet", stable, 1);

        for (int v = 0; v < 5; v++) begin
            run_window(vecs[v].m0, vecs[v].m1, lat);
            chk($sformatf("v%0d_latency", v), lat, 16);
            chk($sformatf("v%0d_count0", v), count0, vecs[v].c0);
            chk($sformatf("v%0d_count1", v), count1, vecs[v].c1);
            chk($sformatf("v%0d_winner", v), winner, vecs[v].win);
            chk($sformatf("v%0d_tie", v), tie, vecs[v].tie);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_valid_drop", v), out_valid, 0);
        end
        chk("no_miss_yet", missed, 0);

        // Back-pressure: 20 stalled cycles with ch1 pulsed twice in HOLD.
        run_window(16'h8431, 16'h0700, lat);
        chk("bp_latency", lat, 16);
        ref_c0 = count0; ref_c1 = count1; ref_w = winner; ref_t = tie;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spike_in = (i == 3 || i == 9) ? 2'b10 : 2'b00;
            tick();
            if (!out_valid || count0 !== ref_c0 || count1 !== ref_c1 ||
                winner !== ref_w || tie !== ref_t) stable = 1'b0;
        end
        spike_in = 2'b00;
        chk("bp_stable", stable, 1);
        chk("bp_missed", missed, 1);
        chk("bp_count0", count0, 5);
        chk("bp_count1", count1, 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        tick();
        tick();
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_missed_sticky", missed, 1);
        chk("bp_counts_retained", {count0, count1}, {8'd5, 8'd3});

        // Reset in the cycle where window_cnt == 7, with nonzero accumulators.
        en = 1'b1;
        tick();
        en = 1'b0;
        spike_in = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spike_in = 2'b00;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_missed", missed, 0);
        chk("mid_rst_counts", {count0, count1}, 0);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) stable = 1'b0;
        end
        chk("mid_rst_idle", stable, 1);
        run_window(16'h0003, 16'h0001, lat);
        chk("fresh_latency", lat, 16);
        chk("fresh_count0", count0, 2);
        chk("fresh_count1", count1, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back tie windows with spikes on both boundary cycles.
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        feed(16'h8001, 16'h8001, lat);
        chk("b2b_w1_latency", lat, 16);
        chk("b2b_w1_counts", {count0, count1}, {8'd2, 8'd2});
        chk("b2b_w1_class", {winner, tie}, 2'b01);
        tick();
        chk("b2b_handshake_drop", out_valid, 0);
        feed(16'h0107, 16'h0107, lat);
        chk("b2b_w2_latency", lat, 16);
        chk("b2b_w2_counts", {count0, count1}, {8'd4, 8'd4});
        chk("b2b_w2_class", {winner, tie}, 2'b01);
        chk("b2b_no_miss", missed, 0);
        en = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();
        chk("b2b_end_idle", out_valid, 0);

        // Saturation on the narrow instance: ch1 every cycle for 32 cycles.
        s_en = 1'b1;
        tick();
        s_en = 1'b0;
        s_spike_in = 2'b10;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_out_valid) begin
                lat = i + 1;
                break;
            end
        end
        s_spike_in = 2'b00;
        chk("sat_latency", lat, 32);
        chk("sat_count1", s_count1, 15);
        chk("sat_count0", s_count0, 0);
        chk("sat_class", {s_winner, s_tie}, 2'b10);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("sat_valid_drop", s_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
